// File: rtl/prog_interval_timer.sv
// Programmable interval timer: enable-gated prescaler produces a tick every
// DIV_COUNT enabled cycles; an up/down counter with reload steps on each tick
// and flags the terminal count (one-shot or auto-reload).
module prog_interval_timer #(
  parameter int unsigned DIV_WIDTH = 26,
  parameter int unsigned DIV_COUNT = 50000000,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic                 start,
  input  logic                 up_down,
  input  logic                 auto_reload,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 tick,
  output logic                 done,
  output logic                 running,
  output logic                 expired
);

  localparam logic [DIV_WIDTH-1:0] PRE_MAX = DIV_WIDTH'(DIV_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t                 state, state_nx;
  logic [DIV_WIDTH-1:0]   pre, pre_nx;
  logic [CNT_WIDTH-1:0]   reload, reload_nx;
  logic [CNT_WIDTH-1:0]   count_nx;
  logic                   tick_nx, done_nx;

  logic                   tick_hit_c;
  logic [CNT_WIDTH-1:0]   term_c;
  logic [CNT_WIDTH-1:0]   step_c;

  // Prescaler expiry this cycle (load and start take priority over a tick)
  assign tick_hit_c = (state == RUN) && enable && (pre == '0) && !load && !start;

  // Terminal value follows the current direction: all ones up, zero down
  assign term_c = {CNT_WIDTH{up_down}};

  // Next count on a tick: reload from terminal, otherwise step one
  assign step_c = (count == term_c) ? reload
                : (up_down ? count + CNT_WIDTH'(1) : count - CNT_WIDTH'(1));

  // State register; running/expired are registered decodes of the next state
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      running <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_nx;
      running <= (state_nx == RUN);
      expired <= (state_nx == EXPIRED);
    end
  end

  // Next-state logic: load > start > terminal tick in one-shot mode
  always_comb begin
    state_nx = state;
    if (load) begin
      state_nx = IDLE;
    end else if (start) begin
      state_nx = RUN;
    end else if (tick_hit_c && (step_c == term_c) && !auto_reload) begin
      state_nx = EXPIRED;
    end
  end

  // Datapath next values: prescaler, count, reload, tick and done pulses
  always_comb begin
    pre_nx    = pre;
    count_nx  = count;
    reload_nx = reload;
    tick_nx   = 1'b0;
    done_nx   = 1'b0;
    if (load) begin
      count_nx  = load_value;
      reload_nx = load_value;
      pre_nx    = PRE_MAX;
    end else if (start) begin
      pre_nx = PRE_MAX;
      if (state != IDLE) begin
        count_nx = reload;
      end
    end else if ((state == RUN) && enable) begin
      if (tick_hit_c) begin
        pre_nx   = PRE_MAX;
        tick_nx  = 1'b1;
        count_nx = step_c;
        done_nx  = (step_c == term_c);
      end else begin
        pre_nx = pre - DIV_WIDTH'(1);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      pre    <= PRE_MAX;
      count  <= '0;
      reload <= '0;
      tick   <= 1'b0;
      done   <= 1'b0;
    end else begin
      pre    <= pre_nx;
      count  <= count_nx;
      reload <= reload_nx;
      tick   <= tick_nx;
      done   <= done_nx;
    end
  end

endmodule

// File: tb/tb_prog_interval_timer.sv
// Self-checking bench for prog_interval_timer (DIV_COUNT=4, CNT_WIDTH=4).
// Expected tick results are queued when a run is launched and checked by a
// monitor as each tick appears.
module tb_prog_interval_timer;

  localparam int unsigned DIV_WIDTH = 3;
  localparam int unsigned DIV_COUNT = 4;
  localparam int unsigned CNT_WIDTH = 4;

  logic                 CLOCK_50;
  logic                 reset;
  logic                 enable;
  logic                 load;
  logic [CNT_WIDTH-1:0] load_value;
  logic                 start;
  logic                 up_down;
  logic                 auto_reload;
  logic [CNT_WIDTH-1:0] count;
  logic                 tick;
  logic                 done;
  logic                 running;
  logic                 expired;

  prog_interval_timer #(
    .DIV_WIDTH(DIV_WIDTH),
    .DIV_COUNT(DIV_COUNT),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .up_down    (up_down),
    .auto_reload(auto_reload),
    .count      (count),
    .tick       (tick),
    .done       (done),
    .running    (running),
    .expired    (expired)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [3:0] cnt;
    logic       dn;
  } exp_t;

  typedef struct packed {
    logic        up;
    logic        ar;
    logic [3:0]  lv;
    logic [2:0]  n;
    logic [23:0] cseq;  // expected counts, first tick in the top nibble
    logic [5:0]  dseq;  // expected done flags, first tick in the top bit
  } vec_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   tick_cnt = 0;
  int   last_tick_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Tick monitor: every tick must match the head of the expectation queue
  always @(negedge CLOCK_50) begin
    if (reset) begin
      chk("done_without_tick", 32'(done & ~tick), 32'd0);
      if (tick) begin
        tick_cnt++;
        last_tick_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_tick: tick with count %0h, none expected (t=%0t)", count, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("tick_count", 32'(count), 32'(e.cnt));
          chk("tick_done", 32'(done), 32'(e.dn));
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge CLOCK_50);
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL tick_timeout: %0d expected ticks never seen", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_tick(input int n0, input int budget);
    int k;
    k = 0;
    while (tick_cnt == n0 && k < budget) begin
      @(negedge CLOCK_50);
      k++;
    end
    n_checks++;
    if (tick_cnt == n0) begin
      n_fail++;
      $display("FAIL tick_wait_timeout: no tick within %0d cycles", budget);
    end
  endtask

  task automatic do_load(input logic [3:0] lv);
    load = 1'b1;
    load_value = lv;
    @(negedge CLOCK_50);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    int ts, t0, n0;
    exp_t e;

    vecs[0] = '{up:1'b0, ar:1'b0, lv:4'd3,  n:3'd3, cseq:24'h210000, dseq:6'b001000};
    vecs[1] = '{up:1'b1, ar:1'b1, lv:4'd13, n:3'd5, cseq:24'hEFDEF0, dseq:6'b010010};
    vecs[2] = '{up:1'b0, ar:1'b1, lv:4'd2,  n:3'd5, cseq:24'h102100, dseq:6'b010010};
    vecs[3] = '{up:1'b1, ar:1'b0, lv:4'd14, n:3'd1, cseq:24'hF00000, dseq:6'b100000};
    vecs[4] = '{up:1'b0, ar:1'b0, lv:4'd0,  n:3'd1, cseq:24'h000000, dseq:6'b100000};
    vecs[5] = '{up:1'b1, ar:1'b1, lv:4'd15, n:3'd3, cseq:24'hFFF000, dseq:6'b111000};
    vecs[6] = '{up:1'b0, ar:1'b1, lv:4'd1,  n:3'd3, cseq:24'h010000, dseq:6'b101000};

    reset = 1'b0;
    enable = 1'b0;
    load = 1'b0;
    load_value = '0;
    start = 1'b0;
    up_down = 1'b0;
    auto_reload = 1'b0;
    #12;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_running", 32'(running), 32'd0);
    chk("reset_expired", 32'(expired), 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b1;
    enable = 1'b1;
    @(negedge CLOCK_50);

    // Table-driven runs: load, start, then every tick checked by the monitor
    for (int i = 0; i < 7; i++) begin
      up_down = vecs[i].up;
      auto_reload = vecs[i].ar;
      do_load(vecs[i].lv);
      chk("load_count", 32'(count), 32'(vecs[i].lv));
      chk("load_idle", 32'(running), 32'd0);
      do_start();
      ts = cyc;
      chk("start_running", 32'(running), 32'd1);
      chk("start_count_kept", 32'(count), 32'(vecs[i].lv));
      for (int k = 0; k < int'(vecs[i].n); k++) begin
        e.cnt = vecs[i].cseq[23 - 4*k -: 4];
        e.dn  = vecs[i].dseq[5 - k];
        exp_q.push_back(e);
      end
      n0 = tick_cnt;
      wait_tick(n0, 8);
      chk("first_tick_latency", 32'(last_tick_cyc - ts), 32'(DIV_COUNT));
      wait_drain(4 * int'(vecs[i].n) + 8);
      if (!vecs[i].ar) begin
        repeat (12) @(negedge CLOCK_50);
        chk("oneshot_expired", 32'(expired), 32'd1);
        chk("oneshot_not_running", 32'(running), 32'd0);
        chk("oneshot_count_held", 32'(count), 32'(e.cnt));
      end else begin
        chk("periodic_running", 32'(running), 32'd1);
      end
    end

    // Restart while running: count returns to reload, prescaler restarts
    up_down = 1'b0;
    auto_reload = 1'b1;
    do_load(4'd3);
    do_start();
    exp_q.push_back('{cnt:4'd2, dn:1'b0});
    exp_q.push_back('{cnt:4'd1, dn:1'b0});
    wait_drain(16);
    chk("pre_restart_count", 32'(count), 32'd1);
    do_start();
    ts = cyc;
    chk("restart_count", 32'(count), 32'd3);
    chk("restart_running", 32'(running), 32'd1);
    exp_q.push_back('{cnt:4'd2, dn:1'b0});
    n0 = tick_cnt;
    wait_tick(n0, 8);
    chk("restart_latency", 32'(last_tick_cyc - ts), 32'(DIV_COUNT));

    // Pause: ten disabled cycles delay the next tick by exactly ten
    exp_q.push_back('{cnt:4'd1, dn:1'b0});
    wait_drain(8);
    t0 = last_tick_cyc;
    enable = 1'b0;
    repeat (10) @(negedge CLOCK_50);
    enable = 1'b1;
    exp_q.push_back('{cnt:4'd0, dn:1'b1});
    n0 = tick_cnt;
    wait_tick(n0, 12);
    chk("pause_interval", 32'(last_tick_cyc - t0), 32'(DIV_COUNT + 10));

    // Load and start together: load wins and the timer stays idle
    load = 1'b1;
    start = 1'b1;
    load_value = 4'd9;
    @(negedge CLOCK_50);
    load = 1'b0;
    start = 1'b0;
    chk("ldst_count", 32'(count), 32'd9);
    chk("ldst_running", 32'(running), 32'd0);
    chk("ldst_expired", 32'(expired), 32'd0);
    repeat (12) @(negedge CLOCK_50);
    chk("ldst_count_held", 32'(count), 32'd9);

    // Asynchronous reset in the middle of a run
    do_load(4'd7);
    do_start();
    exp_q.push_back('{cnt:4'd6, dn:1'b0});
    wait_drain(8);
    @(posedge CLOCK_50);
    #2;
    reset = 1'b0;
    #1;
    chk("midrun_reset_count", 32'(count), 32'd0);
    chk("midrun_reset_tick", 32'(tick), 32'd0);
    chk("midrun_reset_done", 32'(done), 32'd0);
    chk("midrun_reset_running", 32'(running), 32'd0);
    chk("midrun_reset_expired", 32'(expired), 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    chk("post_reset_idle_count", 32'(count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
